// File: rtl/menu_input_pkg.sv
// Shared definitions for the front-panel menu button conditioners:
// repeat-FSM state encoding and the default board timing counts.
package menu_input_pkg;

    localparam logic [1:0] RELEASED_ENC   = 2'd0;
    localparam logic [1:0] HOLD_DELAY_ENC = 2'd1;
    localparam logic [1:0] REPEATING_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_RELEASED   = RELEASED_ENC,
        ST_HOLD_DELAY = HOLD_DELAY_ENC,
        ST_REPEATING  = REPEATING_ENC
    } menu_state_e;

    // 50 MHz board clock: 20 ms debounce, 500 ms repeat delay, 100 ms repeat rate.
    localparam int unsigned DEF_DEBOUNCE_CYCLES     = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 25_000_000;
    localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 5_000_000;
    localparam int unsigned DEF_CNT_W               = 25;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus debounce counter for one raw push-button pin.
// 'stable' is the accepted level, normalised so that 1 means pressed.
module button_debounce
    import menu_input_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw,
    output logic stable
);

    localparam logic             IDLE_RAW = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed_sync;

    assign pressed_sync = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Any sample that agrees with the accepted level restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES differing samples toggles.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (pressed_sync == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= DEB_LAST) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= IDLE_RAW;
            sync2_q  <= IDLE_RAW;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= button_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/menu_button_conditioner.sv
// One menu push-button between the FPGA pin and the NIOS PIO: debounced level for
// in_port plus press strobes with hold-to-auto-repeat for menu scrolling.
module menu_button_conditioner
    import menu_input_pkg::*;
#(
    parameter bit          ACTIVE_LOW          = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
    parameter int unsigned CNT_W               = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_raw,
    input  logic       enable,
    output logic       out_port,
    output logic       press_pulse,
    output logic       repeating,
    output logic [1:0] state_dbg
);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
    localparam bit               REPEAT_EN  = (REPEAT_RATE_CYCLES != 0);

    logic             stable;
    logic             stable_prev_q;
    logic             out_port_q;
    logic             pulse_q;
    logic             repeating_q;
    menu_state_e      state_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_inc;

    button_debounce #(
        .ACTIVE_LOW      (ACTIVE_LOW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .button_raw (button_raw),
        .stable     (stable)
    );

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

    // A press only counts on a stable rising edge, so re-enabling while the
    // button is already held never produces a strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RELEASED;
            timer_q       <= '0;
            stable_prev_q <= 1'b0;
            out_port_q    <= 1'b0;
            pulse_q       <= 1'b0;
            repeating_q   <= 1'b0;
        end else begin
            stable_prev_q <= stable;
            out_port_q    <= stable & enable;
            pulse_q       <= 1'b0;
            repeating_q   <= (state_q == ST_REPEATING);
            if (!stable || !enable) begin
                state_q     <= ST_RELEASED;
                timer_q     <= '0;
                repeating_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RELEASED: begin
                        timer_q <= '0;
                        if (!stable_prev_q) begin
                            state_q <= ST_HOLD_DELAY;
                            pulse_q <= 1'b1;
                        end
                    end
                    ST_HOLD_DELAY: begin
                        if (REPEAT_EN && timer_q >= DELAY_LAST) begin
                            state_q     <= ST_REPEATING;
                            pulse_q     <= 1'b1;
                            timer_q     <= '0;
                            repeating_q <= 1'b1;
                        end else begin
                            timer_q <= timer_inc;
                        end
                    end
                    ST_REPEATING: begin
                        if (timer_q >= RATE_LAST) begin
                            pulse_q <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_inc;
                        end
                    end
                    default: begin
                        state_q <= ST_RELEASED;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign out_port    = out_port_q;
    assign press_pulse = pulse_q;
    assign repeating   = repeating_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_menu_button_conditioner.sv
// Bench for menu_button_conditioner with DEBOUNCE=4, DELAY=20, RATE=5, active-low pin.
// Expected press_pulse cycles are queued by the driver and matched by a monitor.
module tb_menu_button_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned DLY  = 20;
    localparam int unsigned RATE = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       button_raw;
    logic       enable;
    logic       out_port;
    logic       press_pulse;
    logic       repeating;
    logic [1:0] state_dbg;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_c;
    int unsigned t;
    int unsigned r;

    menu_button_conditioner #(
        .ACTIVE_LOW          (1'b1),
        .DEBOUNCE_CYCLES     (DEB),
        .REPEAT_DELAY_CYCLES (DLY),
        .REPEAT_RATE_CYCLES  (RATE),
        .CNT_W               (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .button_raw  (button_raw),
        .enable      (enable),
        .out_port    (out_port),
        .press_pulse (press_pulse),
        .repeating   (repeating),
        .state_dbg   (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (press_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_c = exp_q.pop_front();
                if (exp_c != cyc) begin
                    errors++;
                    $display("FAIL pulse_cycle: pulse at cycle %0d, expected cycle %0d", cyc, exp_c);
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] exp);
        checks++;
        if (state_dbg !== exp) begin
            errors++;
            $display("FAIL %s: state got %0d expected %0d at cycle %0d", name, state_dbg, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        if (target <= cyc) begin
            checks++;
            errors++;
            $display("FAIL schedule: target cycle %0d already passed (now %0d)", target, cyc);
        end else begin
            while (cyc != target) @(negedge clk);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        button_raw = 1'b0;
        enable     = 1'b1;

        // reset with the pin reading pressed
        repeat (3) @(negedge clk);
        check("rst_out", out_port, 1'b0);
        check("rst_pulse", press_pulse, 1'b0);
        check("rst_rep", repeating, 1'b0);
        check_state("rst_state", 2'd0);
        button_raw = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_out", out_port, 1'b0);

        // glitches of 3 cycles never pass the debouncer
        for (int g = 0; g < 5; g++) begin
            button_raw = 1'b0;
            repeat (3) @(negedge clk);
            button_raw = 1'b1;
            repeat (3) @(negedge clk);
            check("glitch_out", out_port, 1'b0);
        end
        repeat (6) @(negedge clk);
        check("glitch_out_end", out_port, 1'b0);

        // press and hold: pulses at T+6, T+26, then every 5
        button_raw = 1'b0;
        t = cyc + 1;
        exp_q.push_back(t + 6);
        for (int k = 0; k < 8; k++) exp_q.push_back(t + 26 + 5 * k);
        wait_cyc(t + 5);
        check("press_out_early", out_port, 1'b0);
        wait_cyc(t + 6);
        check("press_out", out_port, 1'b1);
        check("press_rep0", repeating, 1'b0);
        check_state("press_state", 2'd1);
        wait_cyc(t + 25);
        check("hold_rep_early", repeating, 1'b0);
        wait_cyc(t + 26);
        check("hold_rep", repeating, 1'b1);
        check_state("hold_state", 2'd2);

        // release during REPEATING
        wait_cyc(t + 59);
        button_raw = 1'b1;
        r = t + 60;
        wait_cyc(r + 5);
        check("rel_out_early", out_port, 1'b1);
        check("rel_rep_early", repeating, 1'b1);
        wait_cyc(r + 6);
        check("rel_out", out_port, 1'b0);
        check("rel_rep", repeating, 1'b0);
        check_state("rel_state", 2'd0);
        repeat (20) @(negedge clk);

        // enable dropped while repeating, restored while still held
        button_raw = 1'b0;
        t = cyc + 1;
        exp_q.push_back(t + 6);
        exp_q.push_back(t + 26);
        wait_cyc(t + 28);
        enable = 1'b0;
        wait_cyc(t + 29);
        check("dis_out", out_port, 1'b0);
        check("dis_rep", repeating, 1'b0);
        check_state("dis_state", 2'd0);
        wait_cyc(t + 35);
        enable = 1'b1;
        wait_cyc(t + 36);
        check("reen_out", out_port, 1'b1);
        check("reen_rep", repeating, 1'b0);
        wait_cyc(t + 70);
        button_raw = 1'b1;
        r = t + 71;
        wait_cyc(r + 6);
        check("reen_rel_out", out_port, 1'b0);
        repeat (5) @(negedge clk);
        button_raw = 1'b0;
        t = cyc + 1;
        exp_q.push_back(t + 6);
        wait_cyc(t + 6);
        check("repress_out", out_port, 1'b1);

        // asynchronous reset mid-hold, away from a clock edge
        wait_cyc(t + 10);
        #2 reset_n = 1'b0;
        #1;
        check("async_out", out_port, 1'b0);
        check("async_pulse", press_pulse, 1'b0);
        check("async_rep", repeating, 1'b0);
        check_state("async_state", 2'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        t = cyc + 1;
        exp_q.push_back(t + 6);
        wait_cyc(t + 6);
        check("post_rst_out", out_port, 1'b1);
        button_raw = 1'b1;
        r = cyc + 1;
        wait_cyc(r + 6);
        check("post_rst_rel_out", out_port, 1'b0);
        repeat (10) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, first at cycle %0d",
                     exp_q.size(), exp_q[0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
